// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage.
// Owns the fetch PC, issues word reads over a valid/ready request channel,
// buffers in-order responses in a FIFO and hands one word per handshake to decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect -> FAULT
// state that emits a single fault marker instead of fetching).

// Protocol monitor: a response must never arrive with nothing outstanding.
module fetch_unit_checker (
    input logic clk,
    input logic rst_n,
    input logic imem_rsp_valid,
    input logic none_outstanding
);
    rsp_without_request: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && none_outstanding));
endmodule

module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_fault
);
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam int          CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FAULT = 1'b1} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;          // PC of the next response that will be kept
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] outstanding_next;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   buf_data [FIFO_DEPTH];
    logic [31:0]   buf_pc   [FIFO_DEPTH];
    logic [CW:0]   occupancy;
    logic          req_fire;
    logic          rsp_fire;
    logic          rsp_push;
    logic          pop;
    logic          push;
    logic [31:0]   push_data;
    logic [31:0]   push_pc;
    logic [31:0]   redirect_aligned;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    logic          buf_fault [FIFO_DEPTH];
    logic          marker_pending;
    logic [31:0]   marker_pc;
    logic          marker_push;
    logic          redirect_misaligned;
    logic          push_fault;
`endif

    // Handshake qualification, counter look-ahead and selection of the entry to push
    always_comb begin
        occupancy        = {1'b0, count} + {1'b0, outstanding};
        // Request window counts doomed in-flight reads so the FIFO can never overflow
        imem_req_valid   = rst_n && (state == ST_RUN) && (occupancy < DEPTH_LIM) && !redirect_valid;
        req_fire         = imem_req_valid && imem_req_ready;
        // A response with nothing outstanding is a protocol error and is ignored
        rsp_fire         = imem_rsp_valid && (outstanding != {CW{1'b0}});
        rsp_push         = rsp_fire && (drop == {CW{1'b0}}) && !redirect_valid;
        pop              = (count != {CW{1'b0}}) && ir_ready && !redirect_valid;
        outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_fire);
        redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
        redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
        marker_push         = (state == ST_FAULT) && marker_pending && !redirect_valid;
        push                = rsp_push || marker_push;
        if (marker_push) begin
            push_data  = NOP_WORD;
            push_pc    = marker_pc;
            push_fault = 1'b1;
        end else begin
            push_data  = imem_rsp_data;
            push_pc    = rsp_pc;
            push_fault = 1'b0;
        end
`else
        push      = rsp_push;
        push_data = imem_rsp_data;
        push_pc   = rsp_pc;
`endif
    end

    assign imem_req_addr = fetch_pc;
    assign ir_valid      = (count != {CW{1'b0}});
    assign ir            = buf_data[rd_ptr];
    assign ir_pc         = buf_pc[rd_ptr];
`ifdef FETCH_MISALIGN_TRAP_EN
    assign ir_fault      = buf_fault[rd_ptr];
`else
    assign ir_fault      = 1'b0;
`endif

    // Fetch PC, request/response bookkeeping, FIFO storage and state machine
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count       <= {CW{1'b0}};
            outstanding <= {CW{1'b0}};
            drop        <= {CW{1'b0}};
            rd_ptr      <= {PW{1'b0}};
            wr_ptr      <= {PW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_data[i] <= 32'h0000_0000;
                buf_pc[i]   <= 32'h0000_0000;
`ifdef FETCH_MISALIGN_TRAP_EN
                buf_fault[i] <= 1'b0;
`endif
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            marker_pending <= 1'b0;
            marker_pc      <= 32'h0000_0000;
`endif
        end else if (redirect_valid) begin
            // Flush: everything still in flight, including this cycle's request, is doomed
            count       <= {CW{1'b0}};
            rd_ptr      <= {PW{1'b0}};
            wr_ptr      <= {PW{1'b0}};
            fetch_pc    <= redirect_aligned;
            rsp_pc      <= redirect_aligned;
            outstanding <= outstanding_next;
            drop        <= outstanding_next;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_misaligned) begin
                state          <= ST_FAULT;
                marker_pending <= 1'b1;
                marker_pc      <= redirect_pc;
            end else begin
                state          <= ST_RUN;
                marker_pending <= 1'b0;
            end
`endif
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding_next;
            if (rsp_fire && (drop != {CW{1'b0}})) begin
                drop <= drop - CW'(1'b1);
            end
            if (push) begin
                buf_data[wr_ptr] <= push_data;
                buf_pc[wr_ptr]   <= push_pc;
                wr_ptr           <= wr_ptr + PW'(1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
                buf_fault[wr_ptr] <= push_fault;
`endif
            end
            if (rsp_push) begin
                rsp_pc <= rsp_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1'b1);
            end
            count <= count + CW'(push) - CW'(pop);
`ifdef FETCH_MISALIGN_TRAP_EN
            if (marker_push) begin
                marker_pending <= 1'b0;
            end
`endif
        end
    end

    fetch_unit_checker u_checker (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_rsp_valid   (imem_rsp_valid),
        .none_outstanding (outstanding == {CW{1'b0}})
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// Memory model echoes the request address as data after a programmable latency.
// Reference model: expected instruction stream is "target, target+4, ..." restarting
// at every redirect/reset; requests must walk the same sequence.
module tb_fetch_unit;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_fault;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .ir_pc(ir_pc),
        .ir_fault(ir_fault)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 1;
    bit rand_mem_ready = 1'b0;
    bit rand_ir_ready  = 1'b0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    int accepted = 0;
    int delivered = 0;
    bit exp_empty_next = 1'b0;
    bit fault_mode = 1'b0;
    bit marker_expected = 1'b0;
    bit collision_seen = 1'b0;
    logic [31:0] marker_pc_exp = 32'h0;

    task automatic model_reset();
        mq_addr.delete();
        mq_due.delete();
        exp_pc = RST_PC;
        exp_req = RST_PC;
        accepted = 0;
        delivered = 0;
        exp_empty_next = 1'b0;
        fault_mode = 1'b0;
        marker_expected = 1'b0;
    endtask

    // One clock cycle: called at a negedge, drives memory, checks, returns at the next negedge
    task automatic cycle();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq_addr.pop_front();
            void'(mq_due.pop_front());
        end
        if (rand_mem_ready) imem_req_ready = 1'($urandom_range(0, 1));
        if (rand_ir_ready)  ir_ready       = 1'($urandom_range(0, 1));
        #1;
        if (exp_empty_next) begin
            checks++;
            if (ir_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_empty: ir_valid=%b required 0 (cycle %0d)", ir_valid, cyc);
            end
            exp_empty_next = 1'b0;
        end
        if (redirect_valid && imem_rsp_valid && ir_valid && ir_ready) collision_seen = 1'b1;
        if (redirect_valid) begin
            checks++;
            if (imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL redirect_req_suppress: imem_req_valid=%b required 0", imem_req_valid);
            end
        end else begin
            if (ir_valid && ir_ready) begin
                checks++;
                if (marker_expected) begin
                    if (ir !== 32'h0000_0013 || ir_pc !== marker_pc_exp || ir_fault !== 1'b1) begin
                        errors++;
                        $display("FAIL fault_marker: ir=%h pc=%h fault=%b required ir=00000013 pc=%h fault=1",
                                 ir, ir_pc, ir_fault, marker_pc_exp);
                    end
                    marker_expected = 1'b0;
                end else if (fault_mode) begin
                    errors++;
                    $display("FAIL fault_extra_word: ir=%h pc=%h required no word while faulted", ir, ir_pc);
                end else begin
                    if (ir !== exp_pc || ir_pc !== exp_pc || ir_fault !== 1'b0) begin
                        errors++;
                        $display("FAIL stream: ir=%h pc=%h fault=%b required ir=%h pc=%h fault=0",
                                 ir, ir_pc, ir_fault, exp_pc, exp_pc);
                    end
                    exp_pc = exp_pc + 32'd4;
                    delivered++;
                end
            end
            if (imem_req_valid) begin
                checks++;
                if (fault_mode || imem_req_addr !== exp_req) begin
                    errors++;
                    $display("FAIL req_addr: addr=%h fault_mode=%b required addr=%h and no fault",
                             imem_req_addr, fault_mode, exp_req);
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                mq_addr.push_back(imem_req_addr);
                mq_due.push_back(cyc + lat);
                exp_req = exp_req + 32'd4;
                accepted++;
            end
        end
        if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
                fault_mode = 1'b1;
                marker_expected = 1'b1;
                marker_pc_exp = redirect_pc;
            end else begin
                fault_mode = 1'b0;
                marker_expected = 1'b0;
            end
`endif
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
            exp_req = exp_pc;
            exp_empty_next = 1'b1;
            accepted = 0;
            delivered = 0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; ir_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: %b required 0", imem_req_valid); end
        checks++; if (imem_req_addr !== RST_PC) begin errors++; $display("FAIL rst_req_addr: %h required %h", imem_req_addr, RST_PC); end
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rst_ir_valid: %b required 0", ir_valid); end
        checks++; if (ir !== 32'h0) begin errors++; $display("FAIL rst_ir: %h required 0", ir); end
        checks++; if (ir_pc !== 32'h0) begin errors++; $display("FAIL rst_ir_pc: %h required 0", ir_pc); end
        checks++; if (ir_fault !== 1'b0) begin errors++; $display("FAIL rst_ir_fault: %b required 0", ir_fault); end
        model_reset();
    endtask

    task automatic test_basic_stream();
        lat = 1; imem_req_ready = 1'b1; ir_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
            errors++; $display("FAIL first_req: valid=%b addr=%h required 1/%h", imem_req_valid, imem_req_addr, RST_PC);
        end
        cycle();
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL latency_c1: ir_valid=%b required 0", ir_valid); end
        cycle();
        checks++; if (ir_valid !== 1'b1 || ir_pc !== RST_PC) begin
            errors++; $display("FAIL latency_c2: ir_valid=%b pc=%h required 1/%h", ir_valid, ir_pc, RST_PC);
        end
        repeat (12) cycle();
        checks++; if (delivered < 5) begin errors++; $display("FAIL basic_progress: delivered=%0d required >=5", delivered); end
    endtask

    task automatic test_stall();
        int base;
        ir_ready = 1'b0;
        repeat (10) cycle();
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req: valid=%b required 0", imem_req_valid); end
        checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: ir_valid=%b required 1", ir_valid); end
        checks++; if (accepted - delivered != DEPTH || mq_addr.size() != 0) begin
            errors++; $display("FAIL stall_buffered: buffered=%0d inflight=%0d required %0d/0",
                               accepted - delivered, mq_addr.size(), DEPTH);
        end
        base = delivered;
        ir_ready = 1'b1;
        repeat (10) cycle();
        checks++; if (delivered - base < DEPTH) begin errors++; $display("FAIL stall_release: got %0d required >=%0d", delivered - base, DEPTH); end
    endtask

    task automatic test_redirect_drop();
        int n = 0;
        lat = 3; ir_ready = 1'b1; imem_req_ready = 1'b1;
        while (mq_addr.size() != 2 && n < 20) begin cycle(); n++; end
        checks++; if (mq_addr.size() != 2) begin errors++; $display("FAIL drop_setup: inflight=%0d required 2", mq_addr.size()); end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL redirect_t2: ir_valid=%b required 0", ir_valid); end
        repeat (14) cycle();
        checks++; if (delivered < 2) begin errors++; $display("FAIL drop_resume: delivered=%0d required >=2", delivered); end
    endtask

    task automatic test_redirect_collision();
        int n = 0;
        lat = 1; ir_ready = 1'b1; imem_req_ready = 1'b1;
        while (!(mq_due.size() > 0 && mq_due[0] <= cyc && ir_valid) && n < 20) begin cycle(); n++; end
        collision_seen = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        cycle();
        redirect_valid = 1'b0;
        checks++; if (!collision_seen) begin errors++; $display("FAIL collision_setup: seen=0 required 1"); end
        repeat (10) cycle();
        checks++; if (delivered < 2) begin errors++; $display("FAIL collision_resume: delivered=%0d required >=2", delivered); end
    endtask

    task automatic test_misalign();
        ir_ready = 1'b1; imem_req_ready = 1'b1; lat = 1;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        cycle();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        repeat (6) cycle();
        checks++; if (marker_expected) begin errors++; $display("FAIL marker_missing: seen=0 required 1"); end
        checks++; if (ir_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL fault_idle: ir_valid=%b req=%b required 0/0", ir_valid, imem_req_valid);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0306;
        cycle();
        redirect_valid = 1'b0;
        repeat (6) cycle();
        checks++; if (marker_expected) begin errors++; $display("FAIL marker_refault: seen=0 required 1"); end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        cycle();
        redirect_valid = 1'b0;
`endif
        repeat (10) cycle();
        checks++; if (delivered < 2) begin errors++; $display("FAIL misalign_resume: delivered=%0d required >=2", delivered); end
    endtask

    task automatic test_random();
        rand_mem_ready = 1'b1; rand_ir_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (i % 16 == 0) lat = $urandom_range(1, 3);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc = 32'($urandom_range(0, 1023)) << 2;
            cycle();
            redirect_valid = 1'b0;
        end
        rand_mem_ready = 1'b0; rand_ir_ready = 1'b0;
        imem_req_ready = 1'b1; ir_ready = 1'b1;
        repeat (20) cycle();
        checks++; if (delivered < 3) begin errors++; $display("FAIL random_drain: delivered=%0d required >=3", delivered); end
    endtask

    task automatic test_reset_midstream();
        lat = 1; imem_req_ready = 1'b1; ir_ready = 1'b0;
        repeat (8) cycle();
        checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL midrst_setup: ir_valid=%b required 1", ir_valid); end
        rst_n = 1'b0; imem_rsp_valid = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL midrst_req_comb: %b required 0", imem_req_valid); end
        @(posedge clk); cyc++; @(negedge clk);
        checks++; if (ir_valid !== 1'b0 || imem_req_valid !== 1'b0 || ir !== 32'h0) begin
            errors++; $display("FAIL midrst_state: ir_valid=%b req=%b ir=%h required 0/0/0", ir_valid, imem_req_valid, ir);
        end
        model_reset();
        rst_n = 1'b1; ir_ready = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
            errors++; $display("FAIL midrst_restart: valid=%b addr=%h required 1/%h", imem_req_valid, imem_req_addr, RST_PC);
        end
        repeat (10) cycle();
        checks++; if (delivered < 3) begin errors++; $display("FAIL midrst_resume: delivered=%0d required >=3", delivered); end
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_stall();
        test_redirect_drop();
        test_redirect_collision();
        test_misalign();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
